task_pack: RTL and testbench

//  Joins an argument stream and a continuation stream into one 128-bit task word, {arg, cont}.

---
 rtl/task_pack_if.sv | 27 ++
 rtl/task_pack.sv | 51 +++++
 tb/tb_task_pack.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/task_pack_if.sv
// task_pack_if: AXI-Stream style argument, continuation and task channels of the task packer.
interface task_pack_if #(
    parameter int ARG_W  = 64,
    parameter int CONT_W = 64
);
    logic [ARG_W-1:0]        argIn_TDATA;
    logic                    argIn_TVALID;
    logic                    argIn_TREADY;
    logic [CONT_W-1:0]       contIn_TDATA;
    logic                    contIn_TVALID;
    logic                    contIn_TREADY;
    logic [ARG_W+CONT_W-1:0] taskOut_TDATA;
    logic                    taskOut_TVALID;
    logic                    taskOut_TREADY;

    modport master (
        output argIn_TDATA, argIn_TVALID, input argIn_TREADY,
        output contIn_TDATA, contIn_TVALID, input contIn_TREADY,
        input taskOut_TDATA, taskOut_TVALID, output taskOut_TREADY
    );

    modport slave (
        input argIn_TDATA, argIn_TVALID, output argIn_TREADY,
        input contIn_TDATA, contIn_TVALID, output contIn_TREADY,
        output taskOut_TDATA, taskOut_TVALID, input taskOut_TREADY
    );
endinterface

// File: rtl/task_pack.sv
// task_pack: joins argument and continuation streams into {arg, cont} task words,
// buffered in a DEPTH-entry FIFO so scheduler back-pressure does not stall the PE.
module task_pack #(
    parameter int ARG_W  = 64,
    parameter int CONT_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    task_pack_if.slave  bus,
    output logic [31:0] taskCount
);
    localparam int AW = $clog2(DEPTH);

    logic [ARG_W+CONT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_occ;
    logic [31:0]             r_count;
    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;

    // readies depend only on the partner valid and registered full, never on taskOut_TREADY
    assign w_full              = r_occ == (AW+1)'(DEPTH);
    assign bus.argIn_TREADY    = bus.contIn_TVALID & ~w_full;
    assign bus.contIn_TREADY   = bus.argIn_TVALID & ~w_full;
    assign w_push              = bus.argIn_TVALID & bus.contIn_TVALID & ~w_full;
    assign w_pop               = bus.taskOut_TVALID & bus.taskOut_TREADY;
    assign bus.taskOut_TVALID  = r_occ != '0;
    assign bus.taskOut_TDATA   = r_mem[r_rd_ptr];
    assign taskCount           = r_count;

    always_ff @(posedge ap_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.argIn_TDATA, bus.contIn_TDATA};
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_pop) r_count <= r_count + 32'd1;
            r_occ <= r_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: tb/tb_task_pack.sv
// tb_task_pack: table vectors, directed corner sequences and random traffic against a queue model.
module tb_task_pack;
    localparam int DEPTH = 4;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [31:0] taskCount;

    task_pack_if #(.ARG_W(64), .CONT_W(64)) bus ();

    task_pack #(.ARG_W(64), .CONT_W(64), .DEPTH(DEPTH)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus), .taskCount(taskCount)
    );

    always #5 ap_clk = ~ap_clk;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] q[$];
    int unsigned  m_cnt;

    logic         s_ar, s_cr, s_tv;
    logic [127:0] s_td;
    logic         acc, pop;

    typedef struct {
        logic        av, cv, tr;
        logic [63:0] a, c;
        logic        ar, cr, tv;
        logic [127:0] td;
        logic [31:0] cnt;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic av, input logic cv, input logic [63:0] a, input logic [63:0] c,
                         input logic tr, output logic o_acc, output logic o_pop);
        @(negedge ap_clk);
        bus.argIn_TVALID   = av;
        bus.contIn_TVALID  = cv;
        bus.argIn_TDATA    = a;
        bus.contIn_TDATA   = c;
        bus.taskOut_TREADY = tr;
        #1;
        s_ar = bus.argIn_TREADY;
        s_cr = bus.contIn_TREADY;
        s_tv = bus.taskOut_TVALID;
        s_td = bus.taskOut_TDATA;
        o_acc = av & cv & (q.size() < DEPTH);
        o_pop = tr & (q.size() != 0);
        chk("argIn_TREADY", s_ar, cv && q.size() < DEPTH);
        chk("contIn_TREADY", s_cr, av && q.size() < DEPTH);
        chk("taskOut_TVALID", s_tv, q.size() != 0);
        if (q.size() != 0) chk("taskOut_TDATA", s_td, q[0]);
        chk("taskCount", taskCount, m_cnt);
        @(posedge ap_clk);
        if (o_pop) begin
            void'(q.pop_front());
            m_cnt++;
        end
        if (o_acc) q.push_back({a, c});
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1;
        bus.argIn_TVALID   = 1'b0;
        bus.contIn_TVALID  = 1'b0;
        bus.taskOut_TREADY = 1'b0;
        @(posedge ap_clk);
        q.delete();
        m_cnt = 0;
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    initial begin
        vec_t tbl[8];
        int idx;
        int outs[$];
        logic av, cv, tr;
        logic [63:0] a, c;
        logic [63:0] x1, y1;

        tbl[0] = '{1, 0, 0, 64'd1, 64'd2, 0, 1, 0, 128'd0, 32'd0};
        tbl[1] = '{1, 1, 0, 64'd1, 64'd2, 1, 1, 0, 128'd0, 32'd0};
        tbl[2] = '{0, 0, 1, 64'd0, 64'd0, 0, 0, 1, {64'd1, 64'd2}, 32'd0};
        tbl[3] = '{1, 1, 1, 64'd3, 64'd4, 1, 1, 0, 128'd0, 32'd1};
        tbl[4] = '{1, 1, 1, 64'd5, 64'd6, 1, 1, 1, {64'd3, 64'd4}, 32'd1};
        tbl[5] = '{0, 1, 0, 64'd0, 64'd9, 1, 0, 1, {64'd5, 64'd6}, 32'd2};
        tbl[6] = '{0, 0, 1, 64'd0, 64'd0, 0, 0, 1, {64'd5, 64'd6}, 32'd2};
        tbl[7] = '{0, 0, 0, 64'd0, 64'd0, 0, 0, 0, 128'd0, 32'd3};

        bus.argIn_TDATA  = '0;
        bus.contIn_TDATA = '0;
        do_reset();
        #1;
        chk("reset_tvalid", bus.taskOut_TVALID, 1'b0);
        chk("reset_count", taskCount, 32'd0);

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].av, tbl[i].cv, tbl[i].a, tbl[i].c, tbl[i].tr, acc, pop);
            chk($sformatf("tbl%0d_ar", i), s_ar, tbl[i].ar);
            chk($sformatf("tbl%0d_cr", i), s_cr, tbl[i].cr);
            chk($sformatf("tbl%0d_tv", i), s_tv, tbl[i].tv);
            if (tbl[i].tv) chk($sformatf("tbl%0d_td", i), s_td, tbl[i].td);
            chk($sformatf("tbl%0d_cnt", i), taskCount, tbl[i].cnt);
        end

        // single task
        do_reset();
        cycle(1, 1, 64'hAAAA_0001, 64'h0000_0F00, 1, acc, pop);
        cycle(0, 0, 64'd0, 64'd0, 1, acc, pop);
        chk("t1_tvalid", s_tv, 1'b1);
        chk("t1_tdata", s_td, 128'h0000_0000_AAAA_0001_0000_0000_0000_0F00);
        #1;
        chk("t1_count", taskCount, 32'd1);
        cycle(0, 0, 64'd0, 64'd0, 1, acc, pop);
        chk("t1_tvalid_drop", s_tv, 1'b0);

        // lone argument waits
        do_reset();
        repeat (5) begin
            cycle(1, 0, 64'h77, 64'd0, 0, acc, pop);
            chk("t2_arg_rdy", s_ar, 1'b0);
            chk("t2_no_task", s_tv, 1'b0);
        end
        cycle(1, 1, 64'h77, 64'h88, 0, acc, pop);
        cycle(0, 0, 64'd0, 64'd0, 1, acc, pop);
        chk("t2_task", s_td, {64'h77, 64'h88});
        cycle(0, 0, 64'd0, 64'd0, 0, acc, pop);
        chk("t2_single_push", s_tv, 1'b0);

        // fill with back-pressure, then full-with-pop corner
        do_reset();
        idx = 0;
        repeat (8) begin
            cycle(idx < 6, idx < 6, 64'(idx), 64'(100 + idx), 0, acc, pop);
            if (acc) idx++;
        end
        chk("t3_accepted", 32'(idx), 32'd4);
        chk("t3_full_rdy", s_ar, 1'b0);
        cycle(1, 1, 64'(idx), 64'(100 + idx), 1, acc, pop);
        chk("t4_full_block", s_ar, 1'b0);
        if (pop) outs.push_back(int'(s_td[127:64]));
        if (acc) idx++;
        cycle(1, 1, 64'(idx), 64'(100 + idx), 0, acc, pop);
        chk("t4_push_next", s_ar, 1'b1);
        if (acc) idx++;
        cycle(idx < 6, idx < 6, 64'(idx), 64'(100 + idx), 0, acc, pop);
        chk("t4_full_again", s_ar, 1'b0);
        for (int k = 0; k < 20 && outs.size() < 6; k++) begin
            cycle(idx < 6, idx < 6, 64'(idx), 64'(100 + idx), 1, acc, pop);
            if (pop) outs.push_back(int'(s_td[127:64]));
            if (acc) idx++;
        end
        chk("t3_out_count", 32'(outs.size()), 32'd6);
        foreach (outs[k]) chk($sformatf("t3_order%0d", k), 32'(outs[k]), 32'(k));

        // sustained throughput
        do_reset();
        for (int k = 0; k < 100; k++) cycle(1, 1, 64'(k), ~64'(k), 1, acc, pop);
        #1;
        chk("t5_count", taskCount, 32'd99);

        // reset with tasks buffered
        do_reset();
        for (int k = 0; k < 3; k++) cycle(1, 1, 64'(k + 50), 64'(k + 60), 0, acc, pop);
        do_reset();
        #1;
        chk("t6_tvalid", bus.taskOut_TVALID, 1'b0);
        chk("t6_count", taskCount, 32'd0);
        x1 = 64'h1234_5678_9ABC_DEF0;
        y1 = 64'h0FED_CBA9_8765_4321;
        cycle(1, 1, x1, y1, 0, acc, pop);
        cycle(0, 0, 64'd0, 64'd0, 1, acc, pop);
        chk("t6_first", s_td, {x1, y1});

        // random traffic with AXI hold on pending inputs
        do_reset();
        av = 0; cv = 0; a = '0; c = '0; acc = 0;
        for (int k = 0; k < 400; k++) begin
            if (acc) begin av = 0; cv = 0; end
            if (!av && $urandom_range(0, 3) != 0) begin av = 1; a = {$urandom, $urandom}; end
            if (!cv && $urandom_range(0, 3) != 0) begin cv = 1; c = {$urandom, $urandom}; end
            tr = $urandom_range(0, 99) < ((k / 100) % 2 == 0 ? 70 : 30);
            cycle(av, cv, a, c, tr, acc, pop);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
